alu_issue_ctrl: RTL and testbench

Multi-cycle issue controller that drives the datapath ALU's `in1`/`in2`/`ctl` inputs and consumes its `result`/`zero` outputs. It accepts one decoded-operand request at a time over a valid/ready handshake and translates the RISC-V opcode/funct fields into a 4-bit ALU control code. It registers the ALU operands, captures the ALU result, and resolves BEQ/BNE branch outcomes. It sits between the decode/register-read stage and writeback/PC-select, and is the issuing end of the ALU interface.

---
 rtl/alu_issue_ctrl_if.sv | 34 +++
 rtl/alu_issue_ctrl.sv | 137 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake and ALU operand/result bundle for alu_issue_ctrl.
interface alu_issue_ctrl_if #(
  parameter int unsigned WORDSIZE = 32
);
  logic                req_valid;
  logic                req_ready;
  logic [31:0]         req_instr;
  logic [WORDSIZE-1:0] req_rs1;
  logic [WORDSIZE-1:0] req_rs2;

  logic [WORDSIZE-1:0] alu_in1;
  logic [WORDSIZE-1:0] alu_in2;
  logic [3:0]          alu_ctl;
  logic [WORDSIZE-1:0] alu_result;
  logic                alu_zero;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [WORDSIZE-1:0] rsp_result;
  logic                rsp_taken;
  logic                rsp_illegal;

  // Requester, response consumer and ALU side.
  modport master (
    output req_valid, req_instr, req_rs1, req_rs2, rsp_ready, alu_result, alu_zero,
    input  req_ready, alu_in1, alu_in2, alu_ctl, rsp_valid, rsp_result, rsp_taken, rsp_illegal
  );

  // Issue controller side.
  modport slave (
    input  req_valid, req_instr, req_rs1, req_rs2, rsp_ready, alu_result, alu_zero,
    output req_ready, alu_in1, alu_in2, alu_ctl, rsp_valid, rsp_result, rsp_taken, rsp_illegal
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle ALU issue controller: decodes RISC-V ALU/load/store/branch ops,
// registers ALU operands, captures the result and resolves BEQ/BNE.
module alu_issue_ctrl #(
  parameter int unsigned WORDSIZE = 32
) (
  input logic            clk,
  input logic            rst_n,
  alu_issue_ctrl_if.slave bus
);
  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e              state_q;
  logic                req_ready_q;
  logic [WORDSIZE-1:0] in1_q, in2_q;
  logic [3:0]          ctl_q;
  logic                beq_q, bne_q, ill_q;
  logic                rsp_valid_q, rsp_taken_q, rsp_illegal_q;
  logic [WORDSIZE-1:0] rsp_result_q;

  logic [6:0]          opcode, funct7;
  logic [2:0]          funct3;
  logic [WORDSIZE-1:0] imm_i, imm_s;
  logic [WORDSIZE-1:0] in1_d, in2_d;
  logic [3:0]          ctl_d;
  logic                beq_d, bne_d, ill_d;
  logic                unused_rs1_field;

  assign opcode = bus.req_instr[6:0];
  assign funct3 = bus.req_instr[14:12];
  assign funct7 = bus.req_instr[31:25];
  assign imm_i  = {{(WORDSIZE-12){bus.req_instr[31]}}, bus.req_instr[31:20]};
  assign imm_s  = {{(WORDSIZE-12){bus.req_instr[31]}}, bus.req_instr[31:25], bus.req_instr[11:7]};
  assign unused_rs1_field = ^bus.req_instr[19:15];

  always_comb begin
    in1_d = bus.req_rs1;
    in2_d = bus.req_rs2;
    ctl_d = CTL_ADD;
    beq_d = 1'b0;
    bne_d = 1'b0;
    ill_d = 1'b0;
    unique case (opcode)
      7'b0110011: begin
        if      (funct3 == 3'b000 && funct7 == 7'b0000000) ctl_d = CTL_ADD;
        else if (funct3 == 3'b000 && funct7 == 7'b0100000) ctl_d = CTL_SUB;
        else if (funct3 == 3'b111 && funct7 == 7'b0000000) ctl_d = CTL_AND;
        else if (funct3 == 3'b110 && funct7 == 7'b0000000) ctl_d = CTL_OR;
        else ill_d = 1'b1;
      end
      7'b0010011: begin
        in2_d = imm_i;
        if      (funct3 == 3'b000) ctl_d = CTL_ADD;
        else if (funct3 == 3'b111) ctl_d = CTL_AND;
        else if (funct3 == 3'b110) ctl_d = CTL_OR;
        else ill_d = 1'b1;
      end
      7'b0000011: in2_d = imm_i;
      7'b0100011: in2_d = imm_s;
      7'b1100011: begin
        ctl_d = CTL_SUB;
        if      (funct3 == 3'b000) beq_d = 1'b1;
        else if (funct3 == 3'b001) bne_d = 1'b1;
        else ill_d = 1'b1;
      end
      default: ill_d = 1'b1;
    endcase
    // Illegal requests still issue a harmless ADD of zeros.
    if (ill_d) begin
      in1_d = '0;
      in2_d = '0;
      ctl_d = CTL_ADD;
      beq_d = 1'b0;
      bne_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b1;
      in1_q         <= '0;
      in2_q         <= '0;
      ctl_q         <= CTL_ADD;
      beq_q         <= 1'b0;
      bne_q         <= 1'b0;
      ill_q         <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_taken_q   <= 1'b0;
      rsp_illegal_q <= 1'b0;
      rsp_result_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            ctl_q       <= ctl_d;
            beq_q       <= beq_d;
            bne_q       <= bne_d;
            ill_q       <= ill_d;
            req_ready_q <= 1'b0;
            state_q     <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q  <= ill_q ? '0 : bus.alu_result;
          rsp_taken_q   <= (beq_q & bus.alu_zero) | (bne_q & ~bus.alu_zero);
          rsp_illegal_q <= ill_q;
          rsp_valid_q   <= 1'b1;
          state_q       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.alu_in1     = in1_q;
  assign bus.alu_in2     = in2_q;
  assign bus.alu_ctl     = ctl_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_taken   = rsp_taken_q;
  assign bus.rsp_illegal = rsp_illegal_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU on the issue interface.
module tb_alu_issue_ctrl;
  logic clk;
  logic rst_n;
  int unsigned n_checks;
  int unsigned n_errors;

  alu_issue_ctrl_if #(.WORDSIZE(32)) bus ();

  alu_issue_ctrl #(.WORDSIZE(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    bus.alu_result = '0;
    case (bus.alu_ctl)
      4'b0000: bus.alu_result = bus.alu_in1 & bus.alu_in2;
      4'b0001: bus.alu_result = bus.alu_in1 | bus.alu_in2;
      4'b0010: bus.alu_result = bus.alu_in1 + bus.alu_in2;
      4'b0110: bus.alu_result = bus.alu_in1 - bus.alu_in2;
      default: bus.alu_result = '0;
    endcase
    bus.alu_zero = (bus.alu_result == '0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and walk it through EXEC and RESP, holding off rsp_ready for 'hold' cycles.
  task automatic run(input string tag, input logic [31:0] instr, input logic [31:0] rs1,
                     input logic [31:0] rs2, input logic [31:0] e_in1, input logic [31:0] e_in2,
                     input logic [3:0] e_ctl, input logic [31:0] e_res, input logic e_taken,
                     input logic e_ill, input int unsigned hold);
    int unsigned waited;
    waited = 0;
    while (bus.req_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, "_ready_timeout"}, 32'(waited < 20), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_instr = instr;
    bus.req_rs1   = rs1;
    bus.req_rs2   = rs2;
    tick();
    bus.req_valid = 1'b0;
    bus.req_instr = $urandom;
    bus.req_rs1   = $urandom;
    bus.req_rs2   = $urandom;
    check({tag, "_in1"}, bus.alu_in1, e_in1);
    check({tag, "_in2"}, bus.alu_in2, e_in2);
    check({tag, "_ctl"}, 32'(bus.alu_ctl), 32'(e_ctl));
    check({tag, "_exec_ready"}, 32'(bus.req_ready), 32'd0);
    check({tag, "_exec_valid"}, 32'(bus.rsp_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_result"}, bus.rsp_result, e_res);
    check({tag, "_taken"}, 32'(bus.rsp_taken), 32'(e_taken));
    check({tag, "_illegal"}, 32'(bus.rsp_illegal), 32'(e_ill));
    for (int i = 0; i < int'(hold); i++) begin
      tick();
      check({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
      check({tag, "_hold_result"}, bus.rsp_result, e_res);
      check({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check({tag, "_retired"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_instr = $urandom;
    bus.req_rs1   = $urandom;
    bus.req_rs2   = $urandom;
    bus.rsp_ready = 1'b1;
    repeat (3) tick();
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_taken", 32'(bus.rsp_taken), 32'd0);
    check("rst_rsp_illegal", 32'(bus.rsp_illegal), 32'd0);
    check("rst_rsp_result", bus.rsp_result, 32'd0);
    check("rst_alu_in1", bus.alu_in1, 32'd0);
    check("rst_alu_in2", bus.alu_in2, 32'd0);
    check("rst_alu_ctl", 32'(bus.alu_ctl), 32'd2);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b1;
    tick();

    run("add", {7'b0000000, 5'd3, 5'd2, 3'b000, 5'd1, OP_R}, 32'd7, 32'd5,
        32'd7, 32'd5, 4'b0010, 32'd12, 1'b0, 1'b0, 0);
    run("sub", {7'b0100000, 5'd3, 5'd2, 3'b000, 5'd1, OP_R}, 32'd5, 32'd7,
        32'd5, 32'd7, 4'b0110, 32'hFFFFFFFE, 1'b0, 1'b0, 0);
    run("and", {7'b0000000, 5'd3, 5'd2, 3'b111, 5'd1, OP_R}, 32'hF0F0, 32'h0FF0,
        32'hF0F0, 32'h0FF0, 4'b0000, 32'h00F0, 1'b0, 1'b0, 0);
    run("ori", {12'h00F, 5'd2, 3'b110, 5'd1, OP_I}, 32'h100, 32'hDEAD,
        32'h100, 32'h00F, 4'b0001, 32'h10F, 1'b0, 1'b0, 0);
    run("addi", {12'hFFF, 5'd2, 3'b000, 5'd1, OP_I}, 32'd0, 32'd99,
        32'd0, 32'hFFFFFFFF, 4'b0010, 32'hFFFFFFFF, 1'b0, 1'b0, 0);
    run("sw", {7'h3F, 5'd3, 5'd2, 3'b010, 5'h1F, OP_S}, 32'h100, 32'h55,
        32'h100, 32'h7FF, 4'b0010, 32'h8FF, 1'b0, 1'b0, 0);
    run("beq_eq", {7'b0, 5'd3, 5'd2, 3'b000, 5'd0, OP_B}, 32'd9, 32'd9,
        32'd9, 32'd9, 4'b0110, 32'd0, 1'b1, 1'b0, 0);
    run("bne_eq", {7'b0, 5'd3, 5'd2, 3'b001, 5'd0, OP_B}, 32'd9, 32'd9,
        32'd9, 32'd9, 4'b0110, 32'd0, 1'b0, 1'b0, 0);
    run("beq_ne", {7'b0, 5'd3, 5'd2, 3'b000, 5'd0, OP_B}, 32'd9, 32'd8,
        32'd9, 32'd8, 4'b0110, 32'd1, 1'b0, 1'b0, 0);
    run("bp_add", {7'b0000000, 5'd3, 5'd2, 3'b000, 5'd1, OP_R}, 32'd100, 32'd23,
        32'd100, 32'd23, 4'b0010, 32'd123, 1'b0, 1'b0, 5);
    run("illegal", {25'h1ABCDE, 7'b1101111}, 32'd4, 32'd6,
        32'd0, 32'd0, 4'b0010, 32'd0, 1'b0, 1'b1, 0);

    // Abort during EXEC: no response may appear afterwards.
    bus.req_valid = 1'b1;
    bus.req_instr = {7'b0000000, 5'd3, 5'd2, 3'b000, 5'd1, OP_R};
    bus.req_rs1   = 32'd1;
    bus.req_rs2   = 32'd2;
    tick();
    bus.req_valid = 1'b0;
    check("abort_in_exec", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b0;
    #2;
    check("abort_async_in1", bus.alu_in1, 32'd0);
    check("abort_async_ready", 32'(bus.req_ready), 32'd1);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
      check("abort_idle", 32'(bus.req_ready), 32'd1);
    end
    bus.rsp_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
